// File: rtl/reg_to_apb.sv
// reg_to_apb: bridges a single-outstanding valid/ready register bus onto an APB4 requester.
// Optional macro REG_TO_APB_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYCLES cycles.
module reg_to_apb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      reg_valid_i,
  input  logic                      reg_write_i,
  input  logic [ADDR_WIDTH-1:0]     reg_addr_i,
  input  logic [DATA_WIDTH-1:0]     reg_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   reg_wstrb_i,
  output logic                      reg_ready_o,
  output logic [DATA_WIDTH-1:0]     reg_rdata_o,
  output logic                      reg_error_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_WIDTH-1:0]     paddr_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic [DATA_WIDTH/8-1:0]   pstrb_o,
  output logic [2:0]                pprot_o,
  input  logic                      pready_i,
  input  logic [DATA_WIDTH-1:0]     prdata_i,
  input  logic                      pslverr_i
);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32) || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("reg_to_apb: DATA_WIDTH must be 8, 16 or 32 and TIMEOUT_CYCLES at least 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;

`ifdef REG_TO_APB_TIMEOUT_EN
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] access_cnt;
  logic                 timeout_hit;

  // The counter holds completed ACCESS cycles, so the limit is reached on the edge that
  // would bring it to TIMEOUT_CYCLES.
  assign timeout_hit = (access_cnt == CNT_LAST);
`endif

  assign pprot_o = 3'b000;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      reg_ready_o <= 1'b0;
      reg_rdata_o <= '0;
      reg_error_o <= 1'b0;
`ifdef REG_TO_APB_TIMEOUT_EN
      access_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (reg_valid_i) begin
            pwrite_o <= reg_write_i;
            paddr_o  <= reg_addr_i;
            pwdata_o <= reg_wdata_i;
            pstrb_o  <= reg_write_i ? reg_wstrb_i : '0;
            psel_o   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
`ifdef REG_TO_APB_TIMEOUT_EN
          access_cnt <= '0;
`endif
        end
        ACCESS: begin
          // A completing slave wins over an expiring timeout in the same cycle.
          if (pready_i) begin
            reg_rdata_o <= pwrite_o ? '0 : prdata_i;
            reg_error_o <= pslverr_i;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            reg_ready_o <= 1'b1;
            state       <= RESP;
          end
`ifdef REG_TO_APB_TIMEOUT_EN
          else if (timeout_hit) begin
            reg_rdata_o <= '0;
            reg_error_o <= 1'b1;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            reg_ready_o <= 1'b1;
            state       <= RESP;
          end else begin
            access_cnt <= access_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          reg_ready_o <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_to_apb.sv
// tb_reg_to_apb: drives reg_to_apb with directed and random requests and checks every cycle
// against a transaction-timeline model (SETUP at accept edge, ACCESS for 1+N cycles, then RESP).
`timescale 1ns/1ps
module tb_reg_to_apb;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int T_LIMIT = 4;
  localparam int STUCK   = 1000;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          reg_valid_i = 1'b0;
  logic          reg_write_i = 1'b0;
  logic [AW-1:0] reg_addr_i = '0;
  logic [DW-1:0] reg_wdata_i = '0;
  logic [SW-1:0] reg_wstrb_i = '0;
  logic          reg_ready_o;
  logic [DW-1:0] reg_rdata_o;
  logic          reg_error_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [SW-1:0] pstrb_o;
  logic [2:0]    pprot_o;
  logic          pready_i = 1'b0;
  logic [DW-1:0] prdata_i = '0;
  logic          pslverr_i = 1'b0;

  reg_to_apb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(T_LIMIT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .reg_valid_i(reg_valid_i),
    .reg_write_i(reg_write_i),
    .reg_addr_i(reg_addr_i),
    .reg_wdata_i(reg_wdata_i),
    .reg_wstrb_i(reg_wstrb_i),
    .reg_ready_o(reg_ready_o),
    .reg_rdata_o(reg_rdata_o),
    .reg_error_o(reg_error_o),
    .psel_o(psel_o),
    .penable_o(penable_o),
    .pwrite_o(pwrite_o),
    .paddr_o(paddr_o),
    .pwdata_o(pwdata_o),
    .pstrb_o(pstrb_o),
    .pprot_o(pprot_o),
    .pready_i(pready_i),
    .prdata_i(prdata_i),
    .pslverr_i(pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int            a;
    int            n;
    int            n_eff;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] prdata;
    logic          slverr;
  } txn_t;

  txn_t          cur;
  bit            have_cur = 1'b0;
  logic [DW-1:0] prev_rdata = '0;
  logic          prev_err = 1'b0;
  int            edge_idx = 0;
  int            last_accept_edge = -1;
  bit            drop_reset = 1'b0;
  int            n_checks = 0;
  int            n_fails = 0;

  int            ready_edge = -1;
  int            ready_count = 0;
  logic [DW-1:0] ready_rdata = '0;
  logic          ready_err = 1'b0;
  logic          setup_pwrite = 1'b0;
  logic [SW-1:0] setup_pstrb = '0;
  logic [AW-1:0] setup_paddr = '0;
  int            setup_edges[$];

  // Under the timeout option an ACCESS phase never lasts more than T_LIMIT cycles.
  function automatic int effN(input int n);
`ifdef REG_TO_APB_TIMEOUT_EN
    return (n > T_LIMIT - 1) ? T_LIMIT - 1 : n;
`else
    return n;
`endif
  endfunction

  function automatic logic [DW-1:0] resultData(input txn_t t);
    if (t.n > t.n_eff || t.write) return '0;
    return t.prdata;
  endfunction

  function automatic logic resultErr(input txn_t t);
    if (t.n > t.n_eff) return 1'b1;
    return t.slverr;
  endfunction

  task automatic modelReset();
    have_cur   = 1'b0;
    prev_rdata = '0;
    prev_err   = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_idx, actual, expected);
    end
  endtask

  // One cycle of stimulus, applied at the falling edge before posedge number edge_idx.
  task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb,
                               input int n, input logic [DW-1:0] rd, input logic err);
    int rel;
    bit in_access;
    @(negedge clk_i);
    edge_idx++;
    if (drop_reset) begin
      rst_i      = 1'b0;
      drop_reset = 1'b0;
    end
    reg_valid_i = v;
    reg_write_i = w;
    reg_addr_i  = addr;
    reg_wdata_i = wdata;
    reg_wstrb_i = wstrb;
    rel       = 0;
    in_access = 1'b0;
    if (have_cur) begin
      rel       = edge_idx - 1 - cur.a;
      in_access = (rel >= 1) && (rel <= 1 + cur.n_eff);
    end
    if (in_access && rel == 1 + cur.n) begin
      pready_i  = 1'b1;
      prdata_i  = cur.prdata;
      pslverr_i = cur.slverr;
    end else begin
      pready_i  = in_access ? 1'b0 : 1'($urandom);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
    end
    if (!rst_i && v && (!have_cur || edge_idx - cur.a >= 4 + cur.n_eff)) begin
      if (have_cur) begin
        prev_rdata = resultData(cur);
        prev_err   = resultErr(cur);
      end
      cur.a      = edge_idx;
      cur.n      = n;
      cur.n_eff  = effN(n);
      cur.write  = w;
      cur.addr   = addr;
      cur.wdata  = wdata;
      cur.wstrb  = wstrb;
      cur.prdata = rd;
      cur.slverr = err;
      have_cur   = 1'b1;
      last_accept_edge = edge_idx;
    end
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++)
      applyStimulus(1'b0, 1'($urandom), $urandom, $urandom, SW'($urandom), 0, $urandom, 1'b0);
  endtask

  task automatic runRequest(input logic w, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input logic [SW-1:0] wstrb, input int n, input logic [DW-1:0] rd,
                            input logic err, output int latency);
    int a;
    applyStimulus(1'b1, w, addr, wdata, wstrb, n, rd, err);
    a = last_accept_edge;
    idleCycles(effN(n) + 4);
    // Counted from the acceptance cycle (the cycle ending at edge a) to the RESP cycle.
    latency = (ready_edge >= a) ? ready_edge - a + 1 : -1;
  endtask

  always @(posedge clk_i) begin
    #1;
    compareCycle();
  end

  task automatic compareCycle();
    int            rel;
    logic          e_psel, e_pen, e_ready, e_pwrite, e_err;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, e_rdata;
    logic [SW-1:0] e_pstrb;
    e_psel = 1'b0; e_pen = 1'b0; e_ready = 1'b0; e_pwrite = 1'b0; e_err = 1'b0;
    e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pstrb = '0;
    if (!rst_i) begin
      e_rdata = prev_rdata;
      e_err   = prev_err;
      if (have_cur) begin
        rel      = edge_idx - cur.a;
        e_psel   = (rel <= 1 + cur.n_eff);
        e_pen    = (rel >= 1) && (rel <= 1 + cur.n_eff);
        e_ready  = (rel == 2 + cur.n_eff);
        e_pwrite = cur.write;
        e_paddr  = cur.addr;
        e_pwdata = cur.wdata;
        e_pstrb  = cur.write ? cur.wstrb : '0;
        if (rel >= 2 + cur.n_eff) begin
          e_rdata = resultData(cur);
          e_err   = resultErr(cur);
        end
      end
    end
    checkOutput("psel", psel_o, e_psel);
    checkOutput("penable", penable_o, e_pen);
    checkOutput("pwrite", pwrite_o, e_pwrite);
    checkOutput("paddr", paddr_o, e_paddr);
    checkOutput("pwdata", pwdata_o, e_pwdata);
    checkOutput("pstrb", pstrb_o, e_pstrb);
    checkOutput("pprot", pprot_o, 3'b000);
    checkOutput("reg_ready", reg_ready_o, e_ready);
    checkOutput("reg_rdata", reg_rdata_o, e_rdata);
    checkOutput("reg_error", reg_error_o, e_err);
    if (reg_ready_o) begin
      ready_edge  = edge_idx;
      ready_count++;
      ready_rdata = reg_rdata_o;
      ready_err   = reg_error_o;
    end
    if (psel_o && !penable_o) begin
      setup_edges.push_back(edge_idx);
      setup_pwrite = pwrite_o;
      setup_pstrb  = pstrb_o;
      setup_paddr  = paddr_o;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int diff;
    int ready_before;
    int n;
    modelReset();
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, $urandom, $urandom, SW'($urandom), 0, $urandom, 1'b0);

    $display("[TB] write after reset release");
    drop_reset = 1'b1;
    runRequest(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, lat);
    checkOutput("wr_latency", lat, 3);
    checkOutput("wr_error", ready_err, 1'b0);
    checkOutput("wr_setup_pwrite", setup_pwrite, 1'b1);
    checkOutput("wr_setup_pstrb", setup_pstrb, 4'hF);
    checkOutput("wr_setup_paddr", setup_paddr, 32'h10);

    $display("[TB] read with two wait states");
    runRequest(1'b0, 32'h24, 32'hCAFEF00D, 4'hF, 2, 32'h12345678, 1'b0, lat);
    checkOutput("rd_latency", lat, 5);
    checkOutput("rd_rdata", ready_rdata, 32'h12345678);
    checkOutput("rd_setup_pstrb", setup_pstrb, 4'h0);
    checkOutput("rd_error", ready_err, 1'b0);

    $display("[TB] slave error then clean read");
    runRequest(1'b1, 32'h30, 32'h0BAD0BAD, 4'h3, 1, 32'h55AA55AA, 1'b1, lat);
    checkOutput("slverr_error", ready_err, 1'b1);
    checkOutput("slverr_wr_rdata", ready_rdata, 32'h0);
    runRequest(1'b0, 32'h34, 32'h0, 4'h0, 0, 32'h87654321, 1'b0, lat);
    checkOutput("after_err_error", ready_err, 1'b0);
    checkOutput("after_err_rdata", ready_rdata, 32'h87654321);

    $display("[TB] back-to-back with valid held");
    setup_edges.delete();
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 1'b1, 32'h40, 32'h11223344, 4'hF, 0, 32'h0, 1'b0);
    idleCycles(4);
    diff = (setup_edges.size() >= 2) ? setup_edges[1] - setup_edges[0] : -1;
    checkOutput("b2b_setup_spacing", diff, 4);

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 1'b1, 32'h50, 32'h99887766, 4'hC, 3, 32'h0, 1'b0);
    idleCycles(2);
    #2;
    rst_i = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_async_psel", psel_o, 1'b0);
    checkOutput("rst_async_penable", penable_o, 1'b0);
    ready_before = ready_count;
    idleCycles(2);
    drop_reset = 1'b1;
    idleCycles(8);
    checkOutput("rst_no_ready_pulse", ready_count - ready_before, 0);

`ifdef REG_TO_APB_TIMEOUT_EN
    $display("[TB] timeout with pready stuck low");
    runRequest(1'b0, 32'h60, 32'h0, 4'h0, STUCK, 32'hFFFFFFFF, 1'b0, lat);
    checkOutput("to_latency", lat, 6);
    checkOutput("to_error", ready_err, 1'b1);
    checkOutput("to_rdata", ready_rdata, 32'h0);
    runRequest(1'b0, 32'h64, 32'h0, 4'h0, T_LIMIT - 1, 32'hA5A55A5A, 1'b0, lat);
    checkOutput("limit_latency", lat, 6);
    checkOutput("limit_error", ready_err, 1'b0);
    checkOutput("limit_rdata", ready_rdata, 32'hA5A55A5A);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      n = $urandom_range(0, 3);
`ifdef REG_TO_APB_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) n = STUCK;
`endif
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom), $urandom, $urandom, SW'($urandom),
                    n, $urandom, 1'($urandom));
    end
    idleCycles(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/reg_to_apb.md
REG_TO_APB -- requirements
Module: reg_to_apb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: reg bus and APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width, limited to 8, 16 or 32; strobe width is DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256: ACCESS-phase cycle limit, at least 2, used only under REG_TO_APB_TIMEOUT_EN.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port reg_valid_i, input, 1: reg bus request valid.
REQ-007 SHALL have port reg_write_i, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port reg_addr_i, input, ADDR_WIDTH: request address.
REQ-009 SHALL have port reg_wdata_i, input, DATA_WIDTH: write data.
REQ-010 SHALL have port reg_wstrb_i, input, DATA_WIDTH/8: byte strobes.
REQ-011 SHALL have port reg_ready_o, output, 1: response valid; completes the request.
REQ-012 SHALL have port reg_rdata_o, output, DATA_WIDTH: read data.
REQ-013 SHALL have port reg_error_o, output, 1: error response.
REQ-014 SHALL have APB4 outputs psel_o (1), penable_o (1), pwrite_o (1), paddr_o (ADDR_WIDTH), pwdata_o (DATA_WIDTH), pstrb_o (DATA_WIDTH/8) and pprot_o (3).
REQ-015 SHALL have APB4 inputs pready_i (1), prdata_i (DATA_WIDTH) and pslverr_i (1).

Function
REQ-016 SHALL implement a FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-017 IDLE: when reg_valid_i=1, SHALL capture write, addr, wdata and wstrb (wstrb forced to 0 for reads) into registers and go to SETUP; otherwise stay in IDLE.
REQ-018 SETUP: psel_o=1, penable_o=0, APB fields driven from the capture registers; SHALL go to ACCESS unconditionally after one cycle.
REQ-019 ACCESS: psel_o=1 and penable_o=1, fields held stable; pready_i=1 SHALL capture prdata_i (reads only, else 0) and pslverr_i, then go to RESP; pready_i=0 SHALL stay in ACCESS.
REQ-020 RESP: reg_ready_o=1 for exactly one cycle, reg_rdata_o and reg_error_o from registers, psel_o=0; SHALL then go to IDLE.
REQ-021 A new request SHALL NOT be accepted in the RESP cycle; back-to-back throughput is one transaction per 4+N cycles, where N is APB wait states.
REQ-022 Minimum latency from reg_valid_i accepted in IDLE to reg_ready_o SHALL be 3 cycles (SETUP, ACCESS, RESP).
REQ-023 pprot_o SHALL be constant 3'b000.
REQ-024 Outside SETUP and ACCESS, psel_o and penable_o SHALL be 0; paddr, pwdata, pstrb and pwrite SHALL keep their last values.
REQ-025 Outside RESP, reg_ready_o SHALL be 0; reg_rdata_o and reg_error_o SHALL hold their last captured values.
REQ-026 reg_valid_i dropping after capture (protocol violation) SHALL NOT abort the APB transfer; the transfer completes and RESP still pulses.
REQ-027 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-028 Asserting rst_i SHALL asynchronously force state IDLE; psel_o, penable_o, pwrite_o, reg_ready_o and reg_error_o to 0; paddr_o, pwdata_o, pstrb_o and reg_rdata_o to 0; the timeout counter to 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer silently; no reg_ready_o pulse SHALL follow reset release.
REQ-030 The first request SHALL be accepted on the first rising edge after rst_i deasserts.

Configuration
REQ-031 The macro REG_TO_APB_TIMEOUT_EN, when defined, SHALL compile in an ACCESS cycle counter, clog2(TIMEOUT_CYCLES+1) bits, cleared on entering ACCESS.
REQ-032 With REG_TO_APB_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES with pready_i still 0, the block SHALL drop psel_o/penable_o and go to RESP with reg_error_o=1 and reg_rdata_o=0.
REQ-033 With REG_TO_APB_TIMEOUT_EN defined, pready_i=1 on the same cycle as the limit SHALL take priority and complete the transfer normally.
REQ-034 Without REG_TO_APB_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait indefinitely.

Verification
REQ-035 Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, pready_i=1 -> SETUP then ACCESS with pwrite_o=1, pstrb_o=0xF; reg_ready_o=1 with reg_error_o=0 exactly 3 cycles after acceptance.
REQ-036 Read addr 0x24, pready_i low for 2 ACCESS cycles, prdata_i=0x12345678 -> reg_ready_o 5 cycles after acceptance, reg_rdata_o=0x12345678, pstrb_o=0.
REQ-037 Write with pslverr_i=1 at completion -> reg_error_o=1 in RESP; the next read returns reg_error_o=0.
REQ-038 Two back-to-back requests with reg_valid_i held high -> the second SETUP starts 4 cycles after the first SETUP; no overlap of psel_o.
REQ-039 rst_i pulsed during ACCESS -> psel_o=0 immediately (asynchronously); no reg_ready_o pulse after release.
REQ-040 REG_TO_APB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready_i stuck 0 -> RESP after 4 ACCESS cycles, reg_error_o=1, reg_rdata_o=0.
